// File: rtl/mac_dot_seq_if.sv
// Stream bundle between the operand sequencer, its producer/consumer and the MAC.
// slave is the sequencer's view; master is the environment's view.
interface mac_dot_seq_if #(
   parameter int unsigned N = 8
) ();
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_x;
   logic [N-1:0]   in_w;
   logic [N-1:0]   mac_x;
   logic [N-1:0]   mac_w;
   logic           mac_clr;
   logic [2*N-1:0] mac_out;
   logic [2*N-1:0] result;
   logic           result_valid;
   logic           result_ready;

   modport slave (
      input  in_valid, in_x, in_w, mac_out, result_ready,
      output in_ready, mac_x, mac_w, mac_clr, result, result_valid
   );

   modport master (
      output in_valid, in_x, in_w, mac_out, result_ready,
      input  in_ready, mac_x, mac_w, mac_clr, result, result_valid
   );
endinterface

// File: rtl/mac_dot_seq.sv
// Operand sequencer: buffers LEN (x, w) pairs, clears the MAC, streams the pairs and
// captures the dot product. Optional abort input enabled by MAC_DOT_SEQ_ABORT_EN.
module mac_dot_seq #(
   parameter int unsigned N   = 8,
   parameter int unsigned LEN = 4
) (
   input logic          clk,
   input logic          rst,
`ifdef MAC_DOT_SEQ_ABORT_EN
   input logic          abort,
`endif
   mac_dot_seq_if.slave bus
);
   localparam int unsigned CW = $clog2(LEN + 1);
   localparam int unsigned AW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(LEN - 1);

   typedef enum logic [2:0] {
      StIdle, StLoad, StClear, StRun, StDrain, StResult
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           in_ready_q, in_ready_d;
   logic [N-1:0]   mac_x_q, mac_x_d;
   logic [N-1:0]   mac_w_q, mac_w_d;
   logic           mac_clr_q, mac_clr_d;
   logic [2*N-1:0] result_q, result_d;
   logic           result_valid_q, result_valid_d;
   logic [2*N-1:0] pair_mem_q [LEN];

   logic           accept;
   logic           abort_hit;
   logic [AW-1:0]  wr_idx;
   logic [AW-1:0]  rd_idx;

`ifdef MAC_DOT_SEQ_ABORT_EN
   logic abort_pend_q, abort_pend_d;
   assign abort_hit = abort && (state_q != StIdle);
`else
   assign abort_hit = 1'b0;
`endif

   assign accept = in_ready_q && bus.in_valid;
   assign wr_idx = cnt_q[AW-1:0];
   assign rd_idx = cnt_d[AW-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: state_d = StLoad;
         StLoad: begin
            if (accept) begin
               if (cnt_q == LastCnt) begin
                  cnt_d   = '0;
                  state_d = StClear;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StClear: begin
            cnt_d = '0;
`ifdef MAC_DOT_SEQ_ABORT_EN
            state_d = abort_pend_q ? StLoad : StRun;
`else
            state_d = StRun;
`endif
         end
         StRun: begin
            if (cnt_q == LastCnt) begin
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDrain: begin
            result_d = bus.mac_out;
            state_d  = StResult;
         end
         StResult: begin
            if (bus.result_ready) state_d = StLoad;
         end
         default: state_d = StIdle;
      endcase

      // Abort wins over any accept or result handshake at the same edge.
      if (abort_hit) begin
         state_d  = StClear;
         cnt_d    = '0;
         result_d = result_q;
      end

      // Outputs are registered, so decode them from the state being entered.
      in_ready_d     = (state_d == StLoad);
      mac_clr_d      = (state_d == StClear);
      result_valid_d = (state_d == StResult);
      if (state_d == StRun) begin
         mac_x_d = pair_mem_q[rd_idx][2*N-1:N];
         mac_w_d = pair_mem_q[rd_idx][N-1:0];
      end else begin
         mac_x_d = '0;
         mac_w_d = '0;
      end
   end

`ifdef MAC_DOT_SEQ_ABORT_EN
   always_comb begin
      abort_pend_d = abort_pend_q;
      if (abort_hit) begin
         abort_pend_d = 1'b1;
      end else if (state_q == StClear) begin
         abort_pend_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         in_ready_q     <= 1'b0;
         mac_x_q        <= '0;
         mac_w_q        <= '0;
         mac_clr_q      <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
`ifdef MAC_DOT_SEQ_ABORT_EN
         abort_pend_q   <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         in_ready_q     <= in_ready_d;
         mac_x_q        <= mac_x_d;
         mac_w_q        <= mac_w_d;
         mac_clr_q      <= mac_clr_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
`ifdef MAC_DOT_SEQ_ABORT_EN
         abort_pend_q   <= abort_pend_d;
`endif
      end
   end

   // Pair buffer needs no reset; contents are only read after a full LOAD.
   always_ff @(posedge clk) begin
      if (accept && !abort_hit) begin
         pair_mem_q[wr_idx] <= {bus.in_x, bus.in_w};
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.mac_x        = mac_x_q;
   assign bus.mac_w        = mac_w_q;
   assign bus.mac_clr      = mac_clr_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq: table vectors, random vectors against a dot-product
// model, reset mid-RUN, a 4-bit wrap instance and (when enabled) abort.
module tb_mac_dot_seq;
   localparam int unsigned N0 = 8;
   localparam int unsigned L0 = 4;
   localparam int unsigned N1 = 4;
   localparam int unsigned L1 = 16;

   typedef logic [L0-1:0][N0-1:0] opv_t;
   typedef struct {
      opv_t        xs;
      opv_t        ws;
      int          gap_after;
      int          gap_len;
      int          hold;
      logic [15:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   clr_cnt = 0;

   always #5 clk = ~clk;

   mac_dot_seq_if #(.N(N0)) bus0 ();
   mac_dot_seq_if #(.N(N1)) bus1 ();

`ifdef MAC_DOT_SEQ_ABORT_EN
   logic abort0;
   logic abort1;
`endif

   mac_dot_seq #(.N(N0), .LEN(L0)) u_dut0 (
      .clk   (clk),
      .rst   (rst),
`ifdef MAC_DOT_SEQ_ABORT_EN
      .abort (abort0),
`endif
      .bus   (bus0)
   );

   mac_dot_seq #(.N(N1), .LEN(L1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
`ifdef MAC_DOT_SEQ_ABORT_EN
      .abort (abort1),
`endif
      .bus   (bus1)
   );

   // MAC accumulators as they sit at the top level: mac_clr ORed into the MAC reset.
   logic [2*N0-1:0] acc0;
   logic [2*N1-1:0] acc1;
   logic            mac_rst0;
   logic            mac_rst1;
   assign mac_rst0     = rst | bus0.mac_clr;
   assign mac_rst1     = rst | bus1.mac_clr;
   assign bus0.mac_out = acc0;
   assign bus1.mac_out = acc1;

   always_ff @(posedge clk or posedge mac_rst0) begin
      if (mac_rst0) acc0 <= '0;
      else          acc0 <= acc0 + ({8'd0, bus0.mac_x} * {8'd0, bus0.mac_w});
   end

   always_ff @(posedge clk or posedge mac_rst1) begin
      if (mac_rst1) acc1 <= '0;
      else          acc1 <= acc1 + ({4'd0, bus1.mac_x} * {4'd0, bus1.mac_w});
   end

   always @(posedge clk) begin
      if (bus0.mac_clr) clr_cnt <= clr_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   function automatic opv_t mk(input int a0, input int a1, input int a2, input int a3);
      opv_t v;
      v[0] = 8'(a0);
      v[1] = 8'(a1);
      v[2] = 8'(a2);
      v[3] = 8'(a3);
      return v;
   endfunction

   // Reference: plain dot product reduced modulo 2^(2N).
   function automatic logic [15:0] ref_dot(input opv_t xs, input opv_t ws);
      int unsigned s = 0;
      for (int i = 0; i < int'(L0); i++) s += int'(xs[i]) * int'(ws[i]);
      return 16'(s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_vec(input opv_t xs, input opv_t ws, input int gap_after,
                           input int gap_len);
      int   guard;
      logic rdy;
      for (int i = 0; i < int'(L0); i++) begin
         if (i == gap_after) begin
            bus0.in_valid = 1'b0;
            repeat (gap_len) begin
               tick();
               check("ready_in_stall", 32'(bus0.in_ready), 32'd1);
            end
         end
         bus0.in_valid = 1'b1;
         bus0.in_x     = xs[i];
         bus0.in_w     = ws[i];
         guard = 0;
         do begin
            rdy = bus0.in_ready;
            tick();
            guard++;
         end while (!rdy && guard < 50);
         if (!rdy) check("accept_timeout", 32'd0, 32'd1);
      end
      bus0.in_valid = 1'b0;
   endtask

   // Entered one step after the edge that accepted the last pair (CLEAR cycle).
   task automatic check_pipe(input opv_t xs, input opv_t ws, input logic [15:0] exp,
                             input bit junk);
      if (junk) begin
         bus0.in_valid     = 1'b1;
         bus0.in_x         = 8'($urandom);
         bus0.in_w         = 8'($urandom);
         bus0.result_ready = 1'b1;
      end
      check("clr_pulse", 32'(bus0.mac_clr), 32'd1);
      check("clr_operands", 32'({bus0.mac_x, bus0.mac_w}), 32'd0);
      check("clr_ready", 32'(bus0.in_ready), 32'd0);
      for (int k = 0; k < int'(L0); k++) begin
         tick();
         check("run_x", 32'(bus0.mac_x), 32'(xs[k]));
         check("run_w", 32'(bus0.mac_w), 32'(ws[k]));
         check("run_clr", 32'(bus0.mac_clr), 32'd0);
      end
      tick();
      check("drain_operands", 32'({bus0.mac_x, bus0.mac_w}), 32'd0);
      check("drain_valid", 32'(bus0.result_valid), 32'd0);
      bus0.in_valid     = 1'b0;
      bus0.result_ready = 1'b0;
      tick();
      check("latency_valid", 32'(bus0.result_valid), 32'd1);
      check("result", 32'(bus0.result), 32'(exp));
   endtask

   task automatic take_result(input int hold, input logic [15:0] exp);
      repeat (hold) begin
         tick();
         check("held_valid", 32'(bus0.result_valid), 32'd1);
         check("held_result", 32'(bus0.result), 32'(exp));
      end
      bus0.result_ready = 1'b1;
      tick();
      bus0.result_ready = 1'b0;
      check("consume_valid", 32'(bus0.result_valid), 32'd0);
      check("consume_ready", 32'(bus0.in_ready), 32'd1);
   endtask

   initial begin
      vec_t tbl[5];
      opv_t rx, rw;
      int   c0;
      int   guard;

      tbl[0] = '{xs: mk(5, 3, 7, 8), ws: mk(2, 4, 9, 6), gap_after: -1, gap_len: 0,
                 hold: 0, exp: 16'd133};
      tbl[1] = '{xs: mk(5, 3, 7, 8), ws: mk(2, 4, 9, 6), gap_after: 2, gap_len: 3,
                 hold: 0, exp: 16'd133};
      tbl[2] = '{xs: mk(5, 3, 7, 8), ws: mk(2, 4, 9, 6), gap_after: -1, gap_len: 0,
                 hold: 5, exp: 16'd133};
      // 4 * 255 * 255 = 260100, which wraps in the 16-bit MAC to 63492.
      tbl[3] = '{xs: mk(255, 255, 255, 255), ws: mk(255, 255, 255, 255), gap_after: -1,
                 gap_len: 0, hold: 0, exp: 16'd63492};
      tbl[4] = '{xs: mk(0, 255, 0, 1), ws: mk(9, 0, 7, 1), gap_after: 1, gap_len: 1,
                 hold: 2, exp: 16'd1};

      rst               = 1'b1;
      bus0.in_valid     = 1'b0;
      bus0.in_x         = '0;
      bus0.in_w         = '0;
      bus0.result_ready = 1'b0;
      bus1.in_valid     = 1'b0;
      bus1.in_x         = '0;
      bus1.in_w         = '0;
      bus1.result_ready = 1'b0;
`ifdef MAC_DOT_SEQ_ABORT_EN
      abort0 = 1'b0;
      abort1 = 1'b0;
`endif
      repeat (2) tick();
      check("rst_in_ready", 32'(bus0.in_ready), 32'd0);
      check("rst_operands", 32'({bus0.mac_x, bus0.mac_w}), 32'd0);
      check("rst_clr", 32'(bus0.mac_clr), 32'd0);
      check("rst_result", 32'(bus0.result), 32'd0);
      check("rst_valid", 32'(bus0.result_valid), 32'd0);
      rst = 1'b0;
      tick();
      check("idle_to_load", 32'(bus0.in_ready), 32'd1);

      foreach (tbl[i]) begin
         c0 = clr_cnt;
         load_vec(tbl[i].xs, tbl[i].ws, tbl[i].gap_after, tbl[i].gap_len);
         check_pipe(tbl[i].xs, tbl[i].ws, tbl[i].exp, i[0]);
         take_result(tbl[i].hold, tbl[i].exp);
         check("clr_count", 32'(clr_cnt - c0), 32'd1);
      end

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < int'(L0); i++) begin
            rx[i] = 8'($urandom);
            rw[i] = 8'($urandom);
         end
         load_vec(rx, rw, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
         check_pipe(rx, rw, ref_dot(rx, rw), 1'b1);
         take_result(int'($urandom_range(0, 3)), ref_dot(rx, rw));
      end

      // Reset during the second RUN cycle drops the vector and all outputs.
      load_vec(mk(2, 3, 4, 5), mk(9, 9, 9, 9), -1, 0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("midrun_in_ready", 32'(bus0.in_ready), 32'd0);
      check("midrun_operands", 32'({bus0.mac_x, bus0.mac_w}), 32'd0);
      check("midrun_clr", 32'(bus0.mac_clr), 32'd0);
      check("midrun_result", 32'(bus0.result), 32'd0);
      check("midrun_valid", 32'(bus0.result_valid), 32'd0);
      #2;
      rst = 1'b0;
      check("post_rst_idle", 32'(bus0.in_ready), 32'd0);
      tick();
      check("post_rst_load", 32'(bus0.in_ready), 32'd1);
      load_vec(mk(1, 1, 1, 1), mk(1, 1, 1, 1), -1, 0);
      check_pipe(mk(1, 1, 1, 1), mk(1, 1, 1, 1), 16'd4, 1'b0);
      take_result(0, 16'd4);

`ifdef MAC_DOT_SEQ_ABORT_EN
      c0 = clr_cnt;
      load_vec(mk(9, 9, 9, 9), mk(9, 9, 9, 9), -1, 0);
      tick();
      tick();
      abort0 = 1'b1;
      tick();
      abort0 = 1'b0;
      check("abort_clr", 32'(bus0.mac_clr), 32'd1);
      check("abort_operands", 32'({bus0.mac_x, bus0.mac_w}), 32'd0);
      tick();
      check("abort_to_load", 32'(bus0.in_ready), 32'd1);
      check("abort_no_valid", 32'(bus0.result_valid), 32'd0);
      check("abort_clr_count", 32'(clr_cnt - c0), 32'd2);
      load_vec(mk(5, 3, 7, 8), mk(2, 4, 9, 6), -1, 0);
      check_pipe(mk(5, 3, 7, 8), mk(2, 4, 9, 6), 16'd133, 1'b0);
      take_result(0, 16'd133);
`endif

      // Wrap: 16 * 15 * 15 = 3600, modulo 256 gives 16.
      bus1.in_valid = 1'b1;
      bus1.in_x     = 4'd15;
      bus1.in_w     = 4'd15;
      guard = 0;
      while (!bus1.result_valid && guard < 200) begin
         tick();
         guard++;
      end
      bus1.in_valid = 1'b0;
      check("wrap_valid", 32'(bus1.result_valid), 32'd1);
      check("wrap_result", 32'(bus1.result), 32'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
